// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions for the ALU operand stage: function codes,
// register-address width and the operand-forwarding source select.
package mips_pkg;

  localparam int REG_AW = 5;

  // ALU function codes (MIPS R-type funct field)
  localparam logic [5:0] ALU_SLL  = 6'h00;
  localparam logic [5:0] ALU_SRL  = 6'h02;
  localparam logic [5:0] ALU_SRA  = 6'h03;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_ADDU = 6'h21;
  localparam logic [5:0] ALU_SUB  = 6'h22;
  localparam logic [5:0] ALU_SUBU = 6'h23;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_XOR  = 6'h26;
  localparam logic [5:0] ALU_NOR  = 6'h27;
  localparam logic [5:0] ALU_SLT  = 6'h2A;
  localparam logic [5:0] ALU_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM
  } fwd_sel_t;

endpackage

// File: rtl/alu_fwd_mux.sv
// One operand's producer compare, forwarding source select and hazard term.
// Forwarding from EX/MEM is compiled in only when ALU_FWD_EN is defined.
module alu_fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  i_chk,
  input  logic [REG_AW-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  input  logic                  i_held_valid,
  input  logic                  i_held_wr_en,
  input  logic [REG_AW-1:0]     i_held_rd_addr,
  input  logic                  i_held_is_load,
  input  logic [DATA_WIDTH-1:0] i_ex_result,
  input  logic                  i_mem_wr_en,
  input  logic [REG_AW-1:0]     i_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_hazard
);
  import mips_pkg::*;

  logic     w_nonzero;
  logic     w_held_match;
  logic     w_mem_match;
  fwd_sel_t w_sel;

  // Register 0 is hard-wired, so it never matches a producer.
  assign w_nonzero    = |i_addr;
  assign w_held_match = i_chk & w_nonzero & i_held_valid & i_held_wr_en &
                        (i_held_rd_addr == i_addr);
  assign w_mem_match  = i_chk & w_nonzero & i_mem_wr_en &
                        (i_mem_rd_addr == i_addr);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the ifdef/if chain leaves a latch behind.
  always_comb begin
    w_sel    = FWD_RF;
    o_hazard = 1'b0;
`ifdef ALU_FWD_EN
    if (w_held_match && !i_held_is_load) begin
      w_sel = FWD_EX;
    end else if (w_mem_match) begin
      w_sel = FWD_MEM;
    end
    o_hazard = w_held_match & i_held_is_load;
`else
    o_hazard = w_held_match | w_mem_match;
`endif
  end

`ifndef ALU_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_held_is_load, i_ex_result, i_mem_data};
`endif

  always_comb begin
    o_data = i_rf_data;
    case (w_sel)
      FWD_EX:  o_data = i_ex_result;
      FWD_MEM: o_data = i_mem_data;
      default: o_data = i_rf_data;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register in front of the ALU: operand select, RAW/load-use stall and
// saturating stall counter. Define ALU_FWD_EN to enable EX/MEM forwarding.
module alu_operand_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 6,
  parameter int SHAMT_WIDTH = 5,
  parameter int REG_AW      = mips_pkg::REG_AW,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    id_valid,
  output logic                    id_ready,
  input  logic [REG_AW-1:0]       id_rs_addr,
  input  logic [REG_AW-1:0]       id_rt_addr,
  input  logic [DATA_WIDTH-1:0]   id_rs_data,
  input  logic [DATA_WIDTH-1:0]   id_rt_data,
  input  logic [DATA_WIDTH-1:0]   id_imm,
  input  logic                    id_use_imm,
  input  logic [CTRL_WIDTH-1:0]   id_ctrl,
  input  logic [SHAMT_WIDTH-1:0]  id_shamt,
  input  logic [REG_AW-1:0]       id_rd_addr,
  input  logic                    id_wr_en,
  input  logic                    id_is_load,
  input  logic                    ex_ready,
  input  logic [DATA_WIDTH-1:0]   ex_result,
  input  logic                    mem_wr_en,
  input  logic [REG_AW-1:0]       mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    alu_valid,
  output logic [2*DATA_WIDTH-1:0] alu_dataIn,
  output logic [CTRL_WIDTH-1:0]   alu_ctrl,
  output logic [SHAMT_WIDTH-1:0]  alu_shamt,
  output logic [REG_AW-1:0]       alu_rd_addr,
  output logic                    alu_wr_en,
  output logic                    alu_is_load,
  output logic [CNT_WIDTH-1:0]    stall_cnt
);
  import mips_pkg::*;

  logic                    r_alu_valid;
  logic [2*DATA_WIDTH-1:0] r_alu_data;
  logic [CTRL_WIDTH-1:0]   r_alu_ctrl;
  logic [SHAMT_WIDTH-1:0]  r_alu_shamt;
  logic [REG_AW-1:0]       r_alu_rd_addr;
  logic                    r_alu_wr_en;
  logic                    r_alu_is_load;
  logic [CNT_WIDTH-1:0]    r_stall_cnt;

  logic                    w_adv;
  logic                    w_hazard_a;
  logic                    w_hazard_b;
  logic                    w_hazard;
  logic                    w_capture;
  logic [DATA_WIDTH-1:0]   w_opnd_a;
  logic [DATA_WIDTH-1:0]   w_fwd_b;
  logic [DATA_WIDTH-1:0]   w_opnd_b;

  alu_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs (
    .i_chk          (id_valid),
    .i_addr         (id_rs_addr),
    .i_rf_data      (id_rs_data),
    .i_held_valid   (r_alu_valid),
    .i_held_wr_en   (r_alu_wr_en),
    .i_held_rd_addr (r_alu_rd_addr),
    .i_held_is_load (r_alu_is_load),
    .i_ex_result    (ex_result),
    .i_mem_wr_en    (mem_wr_en),
    .i_mem_rd_addr  (mem_rd_addr),
    .i_mem_data     (mem_data),
    .o_data         (w_opnd_a),
    .o_hazard       (w_hazard_a)
  );

  // rt is not a source when the immediate replaces it.
  alu_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rt (
    .i_chk          (id_valid & ~id_use_imm),
    .i_addr         (id_rt_addr),
    .i_rf_data      (id_rt_data),
    .i_held_valid   (r_alu_valid),
    .i_held_wr_en   (r_alu_wr_en),
    .i_held_rd_addr (r_alu_rd_addr),
    .i_held_is_load (r_alu_is_load),
    .i_ex_result    (ex_result),
    .i_mem_wr_en    (mem_wr_en),
    .i_mem_rd_addr  (mem_rd_addr),
    .i_mem_data     (mem_data),
    .o_data         (w_fwd_b),
    .o_hazard       (w_hazard_b)
  );

  assign w_adv     = ex_ready | ~r_alu_valid;
  assign w_hazard  = w_hazard_a | w_hazard_b;
  assign id_ready  = ~rst & w_adv & ~w_hazard & ~flush;
  assign w_capture = id_valid & id_ready;
  assign w_opnd_b  = id_use_imm ? id_imm : w_fwd_b;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_valid   <= 1'b0;
      r_alu_data    <= '0;
      r_alu_ctrl    <= '0;
      r_alu_shamt   <= '0;
      r_alu_rd_addr <= '0;
      r_alu_wr_en   <= 1'b0;
      r_alu_is_load <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      // A flushed cycle is not a stall: the instruction is dropped, not held.
      if (w_hazard && !flush && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
      if (flush) begin
        r_alu_valid <= 1'b0;
      end else if (w_adv) begin
        r_alu_valid <= w_capture;
        if (w_capture) begin
          r_alu_data    <= {w_opnd_b, w_opnd_a};
          r_alu_ctrl    <= id_ctrl;
          r_alu_shamt   <= id_shamt;
          r_alu_rd_addr <= id_rd_addr;
          r_alu_wr_en   <= id_wr_en;
          r_alu_is_load <= id_is_load;
        end
      end
    end
  end

  assign alu_valid   = r_alu_valid;
  assign alu_dataIn  = r_alu_data;
  assign alu_ctrl    = r_alu_ctrl;
  assign alu_shamt   = r_alu_shamt;
  assign alu_rd_addr = r_alu_rd_addr;
  assign alu_wr_en   = r_alu_wr_en;
  assign alu_is_load = r_alu_is_load;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model; follows ALU_FWD_EN like the RTL.
module tb_alu_operand_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int CW = 6;
  localparam int SW = 5;
  localparam int AW = 5;
  localparam int NW = 4;  // narrow counter so saturation is reachable

  logic          clk = 1'b0;
  logic          rst, flush, id_valid, id_ready;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, ex_result;
  logic          id_use_imm, id_wr_en, id_is_load, ex_ready;
  logic [CW-1:0] id_ctrl;
  logic [SW-1:0] id_shamt;
  logic          mem_wr_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_data;
  logic          alu_valid, alu_wr_en, alu_is_load;
  logic [2*DW-1:0] alu_dataIn;
  logic [CW-1:0] alu_ctrl;
  logic [SW-1:0] alu_shamt;
  logic [AW-1:0] alu_rd_addr;
  logic [NW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SHAMT_WIDTH(SW), .REG_AW(AW), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_ctrl(id_ctrl), .id_shamt(id_shamt), .id_rd_addr(id_rd_addr),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_ready(ex_ready),
    .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr),
    .mem_data(mem_data), .alu_valid(alu_valid), .alu_dataIn(alu_dataIn),
    .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt), .alu_rd_addr(alu_rd_addr),
    .alu_wr_en(alu_wr_en), .alu_is_load(alu_is_load), .stall_cnt(stall_cnt)
  );

  // Transaction-level model: the instruction sitting at the ALU, and the
  // producer the bench itself moves into MEM when the ALU consumes it.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] b;
    logic [DW-1:0] a;
    logic [CW-1:0] ctrl;
    logic [SW-1:0] shamt;
    logic [AW-1:0] rd;
    logic          wr;
    logic          ld;
  } held_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } mem_t;

  held_t         m;
  mem_t          mm;
  logic [NW-1:0] m_cnt;

  assign mem_wr_en   = mm.wr;
  assign mem_rd_addr = mm.rd;
  assign mem_data    = mm.data;

  function automatic bit writes_reg(input logic wr, input logic [AW-1:0] rd,
                                    input logic [AW-1:0] r);
    return wr && (rd == r) && (r != '0);
  endfunction

  // A source is blocked when its newest value cannot yet be delivered.
  function automatic bit src_blocked(input logic [AW-1:0] r);
`ifdef ALU_FWD_EN
    return m.valid && m.ld && writes_reg(m.wr, m.rd, r);
`else
    return (m.valid && writes_reg(m.wr, m.rd, r)) || writes_reg(mm.wr, mm.rd, r);
`endif
  endfunction

  function automatic logic [DW-1:0] src_value(input logic [AW-1:0] r,
                                              input logic [DW-1:0] rf);
`ifdef ALU_FWD_EN
    if (m.valid && !m.ld && writes_reg(m.wr, m.rd, r)) return ex_result;
    if (writes_reg(mm.wr, mm.rd, r)) return mm.data;
`endif
    return rf;
  endfunction

  function automatic bit model_hazard();
    return id_valid && (src_blocked(id_rs_addr) ||
                        (!id_use_imm && src_blocked(id_rt_addr)));
  endfunction

  function automatic bit model_ready();
    return !rst && (ex_ready || !m.valid) && !model_hazard() && !flush;
  endfunction

  // One clock: model computes its next state from the current inputs, the DUT
  // sees the same edge, and the bench returns at the following negedge.
  task automatic tick();
    held_t         nh;
    mem_t          nm;
    logic [NW-1:0] nc;
    nh = m;
    nm = '0;
    nc = m_cnt;
    if (rst) begin
      nh = '0;
      nc = '0;
    end else begin
      if (model_hazard() && !flush && nc != '1) nc = nc + 1'b1;
      if (m.valid && ex_ready) begin
        nm.wr   = m.wr;
        nm.rd   = m.rd;
        nm.data = ex_result;
      end
      if (flush) begin
        nh.valid = 1'b0;
      end else if (ex_ready || !m.valid) begin
        nh.valid = id_valid && model_ready();
        if (nh.valid) begin
          nh.a     = src_value(id_rs_addr, id_rs_data);
          nh.b     = id_use_imm ? id_imm : src_value(id_rt_addr, id_rt_data);
          nh.ctrl  = id_ctrl;
          nh.shamt = id_shamt;
          nh.rd    = id_rd_addr;
          nh.wr    = id_wr_en;
          nh.ld    = id_is_load;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    m     = nh;
    mm    = nm;
    m_cnt = nc;
  endtask

  task automatic drive_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                             input logic [DW-1:0] rs_d, input logic [DW-1:0] rt_d,
                             input logic [DW-1:0] imm, input logic use_imm,
                             input logic [AW-1:0] rd, input logic wr, input logic ld);
    id_valid   = 1'b1;
    id_rs_addr = rs;
    id_rt_addr = rt;
    id_rs_data = rs_d;
    id_rt_data = rt_d;
    id_imm     = imm;
    id_use_imm = use_imm;
    id_ctrl    = ALU_ADD;
    id_shamt   = 5'd1;
    id_rd_addr = rd;
    id_wr_en   = wr;
    id_is_load = ld;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b1;
    ex_result = 32'h0;
    mm = '0;
    m = '0;
    m_cnt = '0;
    drive_instr(5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 1'b0, 5'd3, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_in_rst got=%b want=0", id_ready);
    end
    tick();
    tick();
    n_checks++;
    if ({alu_valid, alu_dataIn, stall_cnt, id_ready, alu_ctrl} !== '0) begin
      n_fail++;
      $display("FAIL reset_state valid=%b data=%h cnt=%0d ready=%b ctrl=%h want all 0",
               alu_valid, alu_dataIn, stall_cnt, id_ready, alu_ctrl);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_capture();
    idle(2);
    drive_instr(5'd1, 5'd9, 32'd5, 32'hAAAA, 32'd7, 1'b1, 5'd2, 1'b1, 1'b0);
    id_ctrl = ALU_ADD;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready got=%b want=1", id_ready);
    end
    tick();
    n_checks++;
    if (alu_dataIn !== {32'd7, 32'd5} || alu_ctrl !== 6'h20 || alu_valid !== 1'b1 ||
        alu_rd_addr !== 5'd2 || alu_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_capture data=%h ctrl=%h valid=%b rd=%0d want data=%h ctrl=20 valid=1 rd=2",
               alu_dataIn, alu_ctrl, alu_valid, alu_rd_addr, {32'd7, 32'd5});
    end
    id_valid = 1'b0;
    tick();
    n_checks++;
    if (alu_valid !== 1'b0 || alu_dataIn !== {32'd7, 32'd5}) begin
      n_fail++;
      $display("FAIL basic_bubble valid=%b data=%h want valid=0 data held", alu_valid, alu_dataIn);
    end
  endtask

  task automatic test_raw();
    logic [NW-1:0] base;
    idle(3);
    drive_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    base = m_cnt;
    drive_instr(5'd3, 5'd0, 32'hDEAD, 32'h0, 32'h2, 1'b1, 5'd7, 1'b1, 1'b0);
    ex_result = 32'h1234;
`ifdef ALU_FWD_EN
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_fwd_ready got=%b want=1", id_ready);
    end
    tick();
    n_checks++;
    if (alu_dataIn[DW-1:0] !== 32'h1234 || stall_cnt !== base) begin
      n_fail++;
      $display("FAIL raw_fwd_operand a=%h cnt=%0d want a=1234 cnt=%0d",
               alu_dataIn[DW-1:0], stall_cnt, base);
    end
`else
    // Producer at the ALU, then in MEM: two stall cycles before capture.
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (id_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL raw_stall_%0d ready=%b want=0", i, id_ready);
      end
      tick();
    end
    id_rs_data = 32'h1234;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_release ready=%b want=1", id_ready);
    end
    tick();
    n_checks++;
    if (alu_dataIn[DW-1:0] !== 32'h1234 || alu_valid !== 1'b1 ||
        stall_cnt !== NW'(base + 2)) begin
      n_fail++;
      $display("FAIL raw_capture a=%h valid=%b cnt=%0d want a=1234 valid=1 cnt=%0d",
               alu_dataIn[DW-1:0], alu_valid, stall_cnt, NW'(base + 2));
    end
`endif
    id_valid = 1'b0;
  endtask

`ifdef ALU_FWD_EN
  task automatic test_load_use();
    logic [NW-1:0] base;
    idle(3);
    drive_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h10, 1'b1, 5'd4, 1'b1, 1'b1);
    tick();
    base = m_cnt;
    drive_instr(5'd0, 5'd4, 32'h1, 32'hDEAD, 32'h0, 1'b0, 5'd8, 1'b1, 1'b0);
    ex_result = 32'hBEEF;
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL loaduse_stall ready=%b want=0", id_ready);
    end
    tick();
    n_checks++;
    if (alu_valid !== 1'b0 || stall_cnt !== NW'(base + 1)) begin
      n_fail++;
      $display("FAIL loaduse_bubble valid=%b cnt=%0d want valid=0 cnt=%0d",
               alu_valid, stall_cnt, NW'(base + 1));
    end
    ex_result = 32'h5555;
    tick();
    n_checks++;
    if (alu_valid !== 1'b1 || alu_dataIn[2*DW-1:DW] !== 32'hBEEF) begin
      n_fail++;
      $display("FAIL loaduse_mem_fwd valid=%b b=%h want valid=1 b=beef",
               alu_valid, alu_dataIn[2*DW-1:DW]);
    end
    id_valid = 1'b0;
  endtask
`endif

  task automatic test_reg_zero();
    idle(3);
    drive_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    drive_instr(5'd0, 5'd0, 32'hA1A1, 32'hB1B1, 32'h0, 1'b0, 5'd1, 1'b0, 1'b0);
    ex_result = 32'hFFFF_0000;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reg0_ready ready=%b want=1", id_ready);
    end
    tick();
    n_checks++;
    if (alu_dataIn !== {32'hB1B1, 32'hA1A1}) begin
      n_fail++;
      $display("FAIL reg0_operands got=%h want=%h", alu_dataIn, {32'hB1B1, 32'hA1A1});
    end
    id_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    idle(3);
    drive_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h4242, 1'b1, 5'd9, 1'b1, 1'b0);
    id_ctrl = ALU_SUB;
    tick();
    drive_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h7777, 1'b1, 5'd10, 1'b0, 1'b0);
    id_ctrl  = ALU_OR;
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (id_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready_%0d ready=%b want=0", i, id_ready);
      end
      tick();
      n_checks++;
      if (alu_valid !== 1'b1 || alu_dataIn !== {32'h4242, 32'h0} ||
          alu_ctrl !== ALU_SUB || alu_rd_addr !== 5'd9) begin
        n_fail++;
        $display("FAIL bp_hold_%0d valid=%b data=%h ctrl=%h rd=%0d want held SUB rd=9",
                 i, alu_valid, alu_dataIn, alu_ctrl, alu_rd_addr);
      end
    end
    ex_ready = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume_ready ready=%b want=1", id_ready);
    end
    tick();
    n_checks++;
    if (alu_dataIn !== {32'h7777, 32'h0} || alu_ctrl !== ALU_OR || alu_rd_addr !== 5'd10) begin
      n_fail++;
      $display("FAIL bp_resume_capture data=%h ctrl=%h rd=%0d want data=%h ctrl=25 rd=10",
               alu_dataIn, alu_ctrl, alu_rd_addr, {32'h7777, 32'h0});
    end
    id_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [NW-1:0] base;
    idle(3);
    drive_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h5A5A, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    base = m_cnt;
    drive_instr(5'd5, 5'd5, 32'h1, 32'h2, 32'h0, 1'b0, 5'd6, 1'b1, 1'b0);
    ex_ready = 1'b0;
    flush    = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready ready=%b want=0", id_ready);
    end
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    n_checks++;
    if (alu_valid !== 1'b0 || stall_cnt !== base || alu_dataIn !== {32'h5A5A, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_kill valid=%b cnt=%0d data=%h want valid=0 cnt=%0d data held",
               alu_valid, stall_cnt, alu_dataIn, base);
    end
  endtask

  task automatic test_saturate();
    logic [NW-1:0] want;
    idle(3);
    drive_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd6, 1'b1, 1'b1);
    tick();
    want = m_cnt;
    drive_instr(5'd6, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0);
    ex_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (want != '1) want = want + 1'b1;
      tick();
    end
    n_checks++;
    if (stall_cnt !== want || want !== '1) begin
      n_fail++;
      $display("FAIL stall_saturate cnt=%0d want=%0d", stall_cnt, {NW{1'b1}});
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++;
      if ({alu_valid, alu_dataIn, alu_ctrl, alu_shamt, alu_rd_addr, alu_wr_en, alu_is_load} !==
          {m.valid, m.b, m.a, m.ctrl, m.shamt, m.rd, m.wr, m.ld} || stall_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL rand_outputs cyc=%0d valid=%b data=%h ctrl=%h rd=%0d cnt=%0d want valid=%b data=%h ctrl=%h rd=%0d cnt=%0d",
                 cyc, alu_valid, alu_dataIn, alu_ctrl, alu_rd_addr, stall_cnt,
                 m.valid, {m.b, m.a}, m.ctrl, m.rd, m_cnt);
      end
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs_addr = AW'($urandom_range(0, 3));
      id_rt_addr = AW'($urandom_range(0, 3));
      id_rd_addr = AW'($urandom_range(0, 3));
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_imm     = $urandom;
      id_use_imm = $urandom_range(0, 1) == 1;
      id_ctrl    = CW'($urandom);
      id_shamt   = SW'($urandom);
      id_wr_en   = $urandom_range(0, 3) != 0;
      id_is_load = $urandom_range(0, 3) == 0;
      ex_ready   = $urandom_range(0, 3) != 0;
      flush      = $urandom_range(0, 15) == 0;
      ex_result  = $urandom;
      #1;
      n_checks++;
      if (id_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, id_ready, model_ready());
      end
      tick();
    end
    id_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_raw();
`ifdef ALU_FWD_EN
    test_load_use();
`endif
    test_reg_zero();
    test_backpressure();
    test_flush();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
